// File: rtl/spi_reg_pkg.sv
// Shared constants for the SPI register responder.
// Frame layout, FSM state encodings and rw-bit meaning.
package spi_reg_pkg;

  localparam int unsigned FRAME_BITS = 27;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_WAIT = 2'd3;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic int unsigned frame_bits(
    input int unsigned aw,
    input int unsigned dw
  );
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Synchroniser for CS/SCLK/MOSI with SCLK edge pulses.
// vld rises once the chains hold only post-reset pin samples.
module spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk_sys,
  input  logic i_rst_n,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic vld
);

  localparam int M = SYNC_STAGES - 1;

  logic [M:0] cs_q;
  logic [M:0] sclk_q;
  logic [M:0] mosi_q;
  logic [M:0] vld_q;
  logic       sclk_d;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cs_q   <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
      vld_q  <= '0;
      sclk_d <= 1'b0;
    end else begin
      cs_q   <= {cs_q[M-1:0], cs_n};
      sclk_q <= {sclk_q[M-1:0], sclk};
      mosi_q <= {mosi_q[M-1:0], mosi};
      vld_q  <= {vld_q[M-1:0], 1'b1};
      sclk_d <= sclk_q[M];
    end
  end

  assign cs_n_s    = cs_q[M];
  assign mosi_s    = mosi_q[M];
  assign vld       = vld_q[M];
  assign sclk_rise = sclk_q[M] & ~sclk_d;
  assign sclk_fall = ~sclk_q[M] & sclk_d;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-map responder (rw, addr, data frames).
// SPI_REG_SLAVE_ERR_CNT_EN maps an abort counter at address all-ones.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int SPI_ADDR_WIDTH = 6,
  parameter int SPI_DATA_WIDTH = 20,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                      i_clk_sys,
  input  logic                      i_rst_n,
  input  logic                      i_spi_cs_n,
  input  logic                      i_spi_sclk,
  input  logic                      i_spi_mosi,
  output logic                      o_spi_miso,
  output logic                      o_spi_miso_oe,
  output logic                      o_wr_en,
  output logic [SPI_ADDR_WIDTH-1:0] o_wr_addr,
  output logic [SPI_DATA_WIDTH-1:0] o_wr_data,
  output logic                      o_frame_err,
  output logic                      o_busy
);

  localparam int AW   = SPI_ADDR_WIDTH;
  localparam int DW   = SPI_DATA_WIDTH;
  localparam int FB   = frame_bits(AW, DW);
  localparam int CW   = $clog2(FB);
  localparam int NREG = 1 << AW;

  localparam logic [CW-1:0] CMD_LAST  = CW'(AW);
  localparam logic [CW-1:0] CMD_DONE  = CW'(AW + 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(FB - 1);

  logic cs_n_s, mosi_s, rise, fall, vld;

  spi_slave_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk_sys(i_clk_sys),
    .i_rst_n  (i_rst_n),
    .cs_n     (i_spi_cs_n),
    .sclk     (i_spi_sclk),
    .mosi     (i_spi_mosi),
    .cs_n_s   (cs_n_s),
    .mosi_s   (mosi_s),
    .sclk_rise(rise),
    .sclk_fall(fall),
    .vld      (vld)
  );

  logic [1:0]    state;
  logic [CW-1:0] bit_cnt;
  logic [AW:0]   cmd_sr;
  logic [DW-1:0] shift_reg;
  logic          oe;
  logic          fetch;
  logic          commit;
  logic [DW-1:0] regmap [NREG];
  logic [DW-1:0] rd_val;
  logic [DW-1:0] ctr_val;
  logic          ctr_hit;

  wire [AW-1:0] cmd_addr = cmd_sr[AW-1:0];
  wire          cmd_rw   = cmd_sr[AW];

`ifdef SPI_REG_SLAVE_ERR_CNT_EN
  logic [7:0] err_cnt;

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      err_cnt <= '0;
    end else if (o_frame_err) begin
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end else if (commit && ctr_hit) begin
      err_cnt <= '0;
    end
  end

  assign ctr_hit = &cmd_addr;
  assign ctr_val = DW'(err_cnt);
`else
  assign ctr_hit = 1'b0;
  assign ctr_val = '0;
`endif

  always_comb begin
    rd_val = regmap[cmd_addr];
    if (ctr_hit) rd_val = ctr_val;
  end

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= ST_WAIT;
      bit_cnt     <= '0;
      cmd_sr      <= '0;
      shift_reg   <= '0;
      oe          <= 1'b0;
      fetch       <= 1'b0;
      commit      <= 1'b0;
      o_wr_en     <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
      o_frame_err <= 1'b0;
      for (int i = 0; i < NREG; i++) regmap[i] <= '0;
    end else begin
      fetch       <= 1'b0;
      commit      <= 1'b0;
      o_wr_en     <= 1'b0;
      o_frame_err <= 1'b0;
      if (fetch && cmd_rw == RW_READ) shift_reg <= rd_val;
      if (commit) begin
        o_wr_en   <= 1'b1;
        o_wr_addr <= cmd_addr;
        o_wr_data <= shift_reg;
        if (!ctr_hit) regmap[cmd_addr] <= shift_reg;
      end
      unique case (state)
        ST_IDLE: begin
          if (!cs_n_s) begin
            state   <= ST_CMD;
            bit_cnt <= '0;
          end
        end
        ST_CMD: begin
          if (cs_n_s) begin
            state       <= ST_IDLE;
            oe          <= 1'b0;
            o_frame_err <= 1'b1;
          end else if (rise && bit_cnt != CMD_DONE) begin
            cmd_sr  <= {cmd_sr[AW-1:0], mosi_s};
            bit_cnt <= bit_cnt + 1'b1;
            fetch   <= (bit_cnt == CMD_LAST);
          end else if (fall && bit_cnt == CMD_DONE) begin
            state <= ST_DATA;
            oe    <= (cmd_rw == RW_READ);
          end
        end
        ST_DATA: begin
          // a final rise seen together with CS high still completes
          if (rise && bit_cnt == DATA_LAST) begin
            state  <= ST_WAIT;
            oe     <= 1'b0;
            commit <= (cmd_rw == RW_WRITE);
            if (cmd_rw == RW_WRITE)
              shift_reg <= {shift_reg[DW-2:0], mosi_s};
          end else if (cs_n_s) begin
            state       <= ST_IDLE;
            oe          <= 1'b0;
            o_frame_err <= 1'b1;
          end else if (rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (cmd_rw == RW_WRITE)
              shift_reg <= {shift_reg[DW-2:0], mosi_s};
          end else if (fall && oe) begin
            shift_reg <= {shift_reg[DW-2:0], 1'b0};
          end
        end
        ST_WAIT: begin
          oe <= 1'b0;
          if (cs_n_s && vld) state <= ST_IDLE;
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  assign o_spi_miso    = oe & shift_reg[DW-1];
  assign o_spi_miso_oe = oe;
  assign o_busy        = ~cs_n_s;

endmodule
